// File: rtl/wbchk_pkg.sv
// Shared definitions for the write-back stream checker: the FSM state
// encoding, the layout of one expected-write table entry, and width helpers
// that keep index/counter ports at least one bit wide for tiny tables.
package wbchk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } wbchk_state_t;

  localparam int DEF_REG_AW = 5;
  localparam int DEF_DATA_W = 32;

  // One table entry in the default MIPS configuration; the memory stores the
  // same {register, data} concatenation at whatever widths it is built with.
  typedef struct packed {
    logic [DEF_REG_AW-1:0] wreg;
    logic [DEF_DATA_W-1:0] data;
  } exp_entry_t;

  // Width of a table index; a single-entry table still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must be able to reach n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/wbchk_exp_mem.sv
// Expected-write table: DEPTH entries of {register, data}, one synchronous
// write port and an asynchronous read port addressed by the run index.
// Contents are deliberately not reset so a table survives a reset and can be
// reused for another run.
module wbchk_exp_mem #(
  parameter int DEPTH  = 16,
  parameter int REG_AW = 5,
  parameter int DATA_W = 32,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [REG_AW-1:0] wreg,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [REG_AW-1:0] rreg,
  output logic [DATA_W-1:0] rdata
);

  logic [REG_AW+DATA_W-1:0] mem [DEPTH];

  // Store an entry; addresses past the table end are dropped.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= {wreg, wdata};
    end
  end

  // Combinational lookup of the entry the next WB event is compared against.
  always_comb begin
    rreg  = '0;
    rdata = '0;
    if (int'(raddr) < DEPTH) begin
      {rreg, rdata} = mem[raddr];
    end
  end

endmodule

// File: rtl/wb_stream_checker.sv
// Write-back stream checker for the MIPS pipeline. Snoops the WB port,
// compares register writes in order against the expected-write table, and
// reports PASS / FAIL / TIMEOUT with counters and first-mismatch capture.
// Optional build macro: WBCHK_SKIP_R0_EN -- when defined, writes to r0 are
// invisible to the checker (not compared, not consumed, not counted).
module wb_stream_checker
  import wbchk_pkg::*;
#(
  parameter int NUM_CHECKS = 16,
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int MAX_CYCLES = 80,
  parameter int CYC_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         exp_we,
  input  logic [idx_w(NUM_CHECKS)-1:0] exp_addr,
  input  logic [REG_AW-1:0]            exp_reg,
  input  logic [DATA_W-1:0]            exp_data,
  input  logic                         wb_regwrite,
  input  logic [REG_AW-1:0]            wb_reg,
  input  logic [DATA_W-1:0]            wb_data,
  output logic [2:0]                   state,
  output logic                         done,
  output logic                         pass,
  output logic [cnt_w(NUM_CHECKS)-1:0] match_cnt,
  output logic [cnt_w(NUM_CHECKS)-1:0] mismatch_cnt,
  output logic [7:0]                   extra_cnt,
  output logic [CYC_W-1:0]             cycle_cnt,
  output logic [idx_w(NUM_CHECKS)-1:0] fail_idx,
  output logic [REG_AW-1:0]            fail_reg,
  output logic [DATA_W-1:0]            fail_data
);

  localparam int IDX_W = idx_w(NUM_CHECKS);
  localparam int CNT_W = cnt_w(NUM_CHECKS);

  wbchk_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  match_q, mismatch_q;
  logic [7:0]        extra_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [IDX_W-1:0]  fail_idx_q;
  logic [REG_AW-1:0] fail_reg_q;
  logic [DATA_W-1:0] fail_data_q;

  logic [REG_AW-1:0] tab_reg;
  logic [DATA_W-1:0] tab_data;
  logic              wb_event;
  logic              entry_ok;
  logic              last_entry;
  logic              budget_out;
  logic              entering_run;

  wbchk_exp_mem #(
    .DEPTH  (NUM_CHECKS),
    .REG_AW (REG_AW),
    .DATA_W (DATA_W),
    .AW     (IDX_W)
  ) u_exp_mem (
    .clk   (clk),
    .we    (exp_we && (state_q == ST_IDLE)),
    .waddr (exp_addr),
    .wreg  (exp_reg),
    .wdata (exp_data),
    .raddr (idx_q),
    .rreg  (tab_reg),
    .rdata (tab_data)
  );

`ifdef WBCHK_SKIP_R0_EN
  assign wb_event = wb_regwrite && (wb_reg != '0);
`else
  assign wb_event = wb_regwrite;
`endif

  assign entry_ok     = (wb_reg == tab_reg) && (wb_data == tab_data);
  assign last_entry   = (idx_q == IDX_W'(NUM_CHECKS - 1));
  assign budget_out   = (cyc_q == CYC_W'(MAX_CYCLES - 1));
  assign entering_run = (state_q != ST_RUN) && (state_d == ST_RUN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a completing event decides the verdict and beats the budget.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (wb_event && last_entry) begin
          state_d = ((mismatch_q == '0) && entry_ok) ? ST_PASS : ST_FAIL;
        end else if (budget_out) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        if (start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters, table index and first-mismatch capture; cleared on each start,
  // frozen after the verdict except for the saturating extra-write count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      match_q     <= '0;
      mismatch_q  <= '0;
      extra_q     <= '0;
      cyc_q       <= '0;
      fail_idx_q  <= '0;
      fail_reg_q  <= '0;
      fail_data_q <= '0;
    end else if (entering_run) begin
      idx_q       <= '0;
      match_q     <= '0;
      mismatch_q  <= '0;
      extra_q     <= '0;
      cyc_q       <= '0;
      fail_idx_q  <= '0;
      fail_reg_q  <= '0;
      fail_data_q <= '0;
    end else if (state_q == ST_RUN) begin
      if (state_d == ST_RUN) begin
        cyc_q <= cyc_q + 1'b1;
      end
      if (wb_event) begin
        if (entry_ok) begin
          match_q <= match_q + 1'b1;
        end else begin
          mismatch_q <= mismatch_q + 1'b1;
          if (mismatch_q == '0) begin
            fail_idx_q  <= idx_q;
            fail_reg_q  <= wb_reg;
            fail_data_q <= wb_data;
          end
        end
        if (!last_entry) begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end else if (state_q != ST_IDLE) begin
      if (wb_event && (extra_q != 8'hFF)) begin
        extra_q <= extra_q + 1'b1;
      end
    end
  end

  assign state        = state_q;
  assign done         = (state_q == ST_PASS) || (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
  assign pass         = (state_q == ST_PASS);
  assign match_cnt    = match_q;
  assign mismatch_cnt = mismatch_q;
  assign extra_cnt    = extra_q;
  assign cycle_cnt    = cyc_q;
  assign fail_idx     = fail_idx_q;
  assign fail_reg     = fail_reg_q;
  assign fail_data    = fail_data_q;

endmodule

// File: tb/tb_wb_stream_checker.sv
// Bench for wb_stream_checker (NUM_CHECKS=3, MAX_CYCLES=10). Each run is a
// per-cycle WB trace; a queue-based reference model derives the expected
// verdict and counters from the trace and the loaded table.
module tb_wb_stream_checker;
  import wbchk_pkg::*;

  localparam int N    = 3;
  localparam int MAXC = 10;
  localparam int DW   = 32;
  localparam int RW   = 5;
  localparam int CW   = 16;
  localparam int IW   = 2;
  localparam int KW   = 2;
  localparam int TMAX = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          exp_we;
  logic [IW-1:0] exp_addr;
  logic [RW-1:0] exp_reg;
  logic [DW-1:0] exp_data;
  logic          wb_regwrite;
  logic [RW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic [2:0]    state;
  logic          done;
  logic          pass;
  logic [KW-1:0] match_cnt;
  logic [KW-1:0] mismatch_cnt;
  logic [7:0]    extra_cnt;
  logic [CW-1:0] cycle_cnt;
  logic [IW-1:0] fail_idx;
  logic [RW-1:0] fail_reg;
  logic [DW-1:0] fail_data;

  int checks   = 0;
  int failures = 0;

  logic [RW-1:0] tab_reg  [N];
  logic [DW-1:0] tab_data [N];
  logic          tr_we    [TMAX];
  logic [RW-1:0] tr_reg   [TMAX];
  logic [DW-1:0] tr_data  [TMAX];
  int            tr_len;

  int            m_state, m_match, m_mismatch, m_extra, m_cycle, m_fidx, m_freg;
  logic [DW-1:0] m_fdata;

  wb_stream_checker #(
    .NUM_CHECKS (N),
    .DATA_W     (DW),
    .REG_AW     (RW),
    .MAX_CYCLES (MAXC),
    .CYC_W      (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .exp_we       (exp_we),
    .exp_addr     (exp_addr),
    .exp_reg      (exp_reg),
    .exp_data     (exp_data),
    .wb_regwrite  (wb_regwrite),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .state        (state),
    .done         (done),
    .pass         (pass),
    .match_cnt    (match_cnt),
    .mismatch_cnt (mismatch_cnt),
    .extra_cnt    (extra_cnt),
    .cycle_cnt    (cycle_cnt),
    .fail_idx     (fail_idx),
    .fail_reg     (fail_reg),
    .fail_data    (fail_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_state"}, 64'(state), 64'(0));
    checkOutput({tag, "_done"}, 64'(done), 64'(0));
    checkOutput({tag, "_pass"}, 64'(pass), 64'(0));
    checkOutput({tag, "_match"}, 64'(match_cnt), 64'(0));
    checkOutput({tag, "_mismatch"}, 64'(mismatch_cnt), 64'(0));
    checkOutput({tag, "_extra"}, 64'(extra_cnt), 64'(0));
    checkOutput({tag, "_cycle"}, 64'(cycle_cnt), 64'(0));
    checkOutput({tag, "_fidx"}, 64'(fail_idx), 64'(0));
    checkOutput({tag, "_freg"}, 64'(fail_reg), 64'(0));
    checkOutput({tag, "_fdata"}, 64'(fail_data), 64'(0));
  endtask

  task automatic loadTable(input int r0, input int d0, input int r1, input int d1, input int r2, input int d2);
    int rr [N];
    int dd [N];
    rr = '{r0, r1, r2};
    dd = '{d0, d1, d2};
    for (int i = 0; i < N; i++) begin
      tab_reg[i]  = RW'(rr[i]);
      tab_data[i] = DW'(dd[i]);
      exp_we   = 1'b1;
      exp_addr = IW'(i);
      exp_reg  = RW'(rr[i]);
      exp_data = DW'(dd[i]);
      tick();
    end
    exp_we = 1'b0;
  endtask

  task automatic clearTrace(input int len);
    tr_len = len;
    for (int i = 0; i < TMAX; i++) begin
      tr_we[i]   = 1'b0;
      tr_reg[i]  = '0;
      tr_data[i] = '0;
    end
  endtask

  task automatic putWrite(input int c, input int r, input int d);
    tr_we[c]   = 1'b1;
    tr_reg[c]  = RW'(r);
    tr_data[c] = DW'(d);
  endtask

  // Pulse start, then play the trace one cycle per entry.
  task automatic applyStimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < tr_len; c++) begin
      wb_regwrite = tr_we[c];
      wb_reg      = tr_reg[c];
      wb_data     = tr_data[c];
      tick();
    end
    wb_regwrite = 1'b0;
    wb_reg      = '0;
    wb_data     = '0;
  endtask

  // Reference: expected writes wait in a queue and are consumed in order;
  // an empty queue gives the verdict, the last budget cycle gives TIMEOUT.
  task automatic computeExpected();
    int pending [$];
    int k;
    bit ev;
    pending = {};
    for (int i = 0; i < N; i++) pending.push_back(i);
    m_state = 1; m_match = 0; m_mismatch = 0; m_extra = 0; m_cycle = 0;
    m_fidx = 0; m_freg = 0; m_fdata = '0;
    for (int c = 0; c < tr_len; c++) begin
      ev = tr_we[c];
`ifdef WBCHK_SKIP_R0_EN
      if (tr_reg[c] == '0) ev = 1'b0;
`endif
      if (m_state == 1) begin
        if (ev) begin
          k = pending.pop_front();
          if (tr_reg[c] == tab_reg[k] && tr_data[c] == tab_data[k]) begin
            m_match++;
          end else begin
            if (m_mismatch == 0) begin
              m_fidx  = k;
              m_freg  = int'(tr_reg[c]);
              m_fdata = tr_data[c];
            end
            m_mismatch++;
          end
        end
        if (pending.size() == 0) m_state = (m_mismatch == 0) ? 2 : 3;
        else if (m_cycle == MAXC - 1) m_state = 4;
        else m_cycle++;
      end else if (ev && m_extra < 255) begin
        m_extra++;
      end
    end
  endtask

  task automatic checkRun(input string tag);
    computeExpected();
    checkOutput({tag, "_state"}, 64'(state), 64'(m_state));
    checkOutput({tag, "_done"}, 64'(done), 64'(m_state >= 2));
    checkOutput({tag, "_pass"}, 64'(pass), 64'(m_state == 2));
    checkOutput({tag, "_match"}, 64'(match_cnt), 64'(m_match));
    checkOutput({tag, "_mismatch"}, 64'(mismatch_cnt), 64'(m_mismatch));
    checkOutput({tag, "_extra"}, 64'(extra_cnt), 64'(m_extra));
    checkOutput({tag, "_cycle"}, 64'(cycle_cnt), 64'(m_cycle));
    checkOutput({tag, "_fidx"}, 64'(fail_idx), 64'(m_fidx));
    checkOutput({tag, "_freg"}, 64'(fail_reg), 64'(m_freg));
    checkOutput({tag, "_fdata"}, 64'(fail_data), 64'(m_fdata));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_reg = '0; exp_data = '0;
    wb_regwrite = 1'b0; wb_reg = '0; wb_data = '0;
    tick();
    tick();
    checkZero("reset");
    rst = 1'b0;
    tick();

    // WB activity in IDLE must not count.
    wb_regwrite = 1'b1; wb_reg = 5'd1; wb_data = 32'd5;
    tick();
    tick();
    wb_regwrite = 1'b0;
    checkZero("idle_wb");

    loadTable(1, 5, 2, 7, 1, 12);

    // 1: in-order correct writes with a random gap -> PASS.
    clearTrace(12);
    putWrite(1, 1, 5);
    putWrite(3, 2, 7);
    putWrite(4 + int'($urandom_range(0, 4)), 1, 12);
    applyStimulus();
    checkRun("t1");
    checkOutput("t1_pass_direct", 64'(state), 64'(ST_PASS));
    checkOutput("t1_match3", 64'(match_cnt), 64'(3));

    // 2: third write carries the wrong data -> FAIL at index 2.
    clearTrace(12);
    putWrite(0, 1, 5);
    putWrite(2, 2, 7);
    putWrite(5, 1, 13);
    applyStimulus();
    checkRun("t2");
    checkOutput("t2_fail_direct", 64'(state), 64'(ST_FAIL));
    checkOutput("t2_fdata13", 64'(fail_data), 64'(13));

    // 3: only two writes -> TIMEOUT with cycle_cnt parked at 9.
    clearTrace(12);
    putWrite(1, 1, 5);
    putWrite(4, 2, 7);
    applyStimulus();
    checkRun("t3");
    checkOutput("t3_timeout_direct", 64'(state), 64'(ST_TIMEOUT));
    checkOutput("t3_cycle9", 64'(cycle_cnt), 64'(9));

    // Table writes outside IDLE must be dropped.
    exp_we = 1'b1; exp_addr = 2'd0; exp_reg = 5'd9; exp_data = 32'hFFFF;
    tick();
    exp_we = 1'b0;

    // 4: final write lands on the last budget cycle -> PASS wins.
    clearTrace(12);
    putWrite(2, 1, 5);
    putWrite(5, 2, 7);
    putWrite(9, 1, 12);
    applyStimulus();
    checkRun("t4");
    checkOutput("t4_pass_direct", 64'(state), 64'(ST_PASS));

    // 5: an r0 write between valid writes.
    clearTrace(12);
    putWrite(0, 1, 5);
    putWrite(1, 0, 0);
    putWrite(2, 2, 7);
    putWrite(3, 1, 12);
    applyStimulus();
    checkRun("t5");
`ifdef WBCHK_SKIP_R0_EN
    checkOutput("t5_state_direct", 64'(state), 64'(ST_PASS));
`else
    checkOutput("t5_state_direct", 64'(state), 64'(ST_FAIL));
    checkOutput("t5_fidx1", 64'(fail_idx), 64'(1));
`endif

    // 6: reset mid-run clears everything asynchronously; table survives.
    start = 1'b1;
    tick();
    start = 1'b0;
    wb_regwrite = 1'b1; wb_reg = 5'd1; wb_data = 32'd5;
    tick();
    wb_reg = 5'd2; wb_data = 32'd99;
    tick();
    wb_regwrite = 1'b0;
    rst = 1'b1;
    #1;
    checkZero("rst_mid");
    tick();
    rst = 1'b0;
    tick();
    clearTrace(12);
    putWrite(0, 1, 5);
    putWrite(1, 2, 7);
    putWrite(2, 1, 12);
    putWrite(5, 3, int'($urandom_range(1, 1000)));
    putWrite(7, 4, int'($urandom_range(1, 1000)));
    applyStimulus();
    checkRun("t6");
    checkOutput("t6_extra2", 64'(extra_cnt), 64'(2));

    // Randomized runs over a tiny register/data alphabet so all verdicts occur.
    for (int it = 0; it < 20; it++) begin
      int k;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      loadTable(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      clearTrace(int'($urandom_range(10, 15)));
      for (int c = 0; c < tr_len; c++) begin
        if ($urandom_range(0, 2) != 0) begin
          if ($urandom_range(0, 1) == 1) begin
            k = int'($urandom_range(0, N - 1));
            putWrite(c, int'(tab_reg[k]), int'(tab_data[k]));
          end else begin
            putWrite(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
          end
        end
      end
      applyStimulus();
      checkRun($sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
